// File: rtl/fft_reorder_if.sv
// Streaming handshake bundle for fft_reorder_buf: bit-reversed samples in, natural-order samples out.
// out_last is present only when FFT_REORDER_LAST_EN is defined.
interface fft_reorder_if #(
    parameter int WIDTH = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_r;
    logic [WIDTH-1:0] in_i;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_r;
    logic [WIDTH-1:0] out_i;
`ifdef FFT_REORDER_LAST_EN
    logic             out_last;
`endif

    modport slave (
        input  in_valid, in_r, in_i, out_ready,
`ifdef FFT_REORDER_LAST_EN
        output out_last,
`endif
        output in_ready, out_valid, out_r, out_i
    );

    modport master (
        output in_valid, in_r, in_i, out_ready,
`ifdef FFT_REORDER_LAST_EN
        input  out_last,
`endif
        input  in_ready, out_valid, out_r, out_i
    );
endinterface

// File: rtl/fft_reorder_buf.sv
// Ping-pong bit-reversal reorder buffer: writes frame k-th sample to bitrev(k), reads naturally.
// Optional macro FFT_REORDER_LAST_EN adds out_last flagging the final bin of each frame.
module fft_reorder_buf #(
    parameter int LOG2N = 5,
    parameter int WIDTH = 16
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          flush,
    fft_reorder_if.slave  bus
);
    localparam int N = 1 << LOG2N;
    typedef logic [LOG2N-1:0] idx_t;

    function automatic idx_t bitrev(input idx_t k);
        idx_t r;
        for (int i = 0; i < LOG2N; i++) r[i] = k[LOG2N-1-i];
        return r;
    endfunction

    // Bank contents are deliberately left uncleared; full[] gates every read.
    logic [2*WIDTH-1:0] mem [2][N];

    logic [1:0]       full, full_nxt;
    logic             wsel, rsel;
    idx_t             wcnt, rcnt;
    logic             out_valid;
    logic [WIDTH-1:0] out_r, out_i;
    logic             wr_fire, wr_last, rd_load, rd_last;

    assign bus.in_ready  = ~full[wsel];
    assign bus.out_valid = out_valid;
    assign bus.out_r     = out_r;
    assign bus.out_i     = out_i;

    assign wr_fire = bus.in_valid & ~full[wsel] & ~flush;
    assign wr_last = wr_fire & (wcnt == idx_t'(N-1));
    assign rd_load = full[rsel] & (~out_valid | bus.out_ready) & ~flush;
    assign rd_last = rd_load & (rcnt == idx_t'(N-1));

    // A fill and a free on the same edge always target different banks.
    always_comb begin
        full_nxt = full;
        if (wr_last) full_nxt[wsel] = 1'b1;
        if (rd_last) full_nxt[rsel] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (wr_fire) mem[wsel][bitrev(wcnt)] <= {bus.in_r, bus.in_i};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            full      <= '0;
            wsel      <= 1'b0;
            rsel      <= 1'b0;
            wcnt      <= '0;
            rcnt      <= '0;
            out_valid <= 1'b0;
        end else if (flush) begin
            full      <= '0;
            wsel      <= 1'b0;
            rsel      <= 1'b0;
            wcnt      <= '0;
            rcnt      <= '0;
            out_valid <= 1'b0;
        end else begin
            full <= full_nxt;
            if (wr_fire) wcnt <= wcnt + 1'b1;
            if (wr_last) wsel <= ~wsel;
            if (rd_load) rcnt <= rcnt + 1'b1;
            if (rd_last) rsel <= ~rsel;
            if (rd_load)             out_valid <= 1'b1;
            else if (bus.out_ready)  out_valid <= 1'b0;
        end
    end

    // Data register holds through flush; only valid is withdrawn.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_r <= '0;
            out_i <= '0;
        end else if (rd_load) begin
            {out_r, out_i} <= mem[rsel][rcnt];
        end
    end

`ifdef FFT_REORDER_LAST_EN
    logic out_last;
    assign bus.out_last = out_last;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)       out_last <= 1'b0;
        else if (flush)   out_last <= 1'b0;
        else if (rd_load) out_last <= (rcnt == idx_t'(N-1));
    end
`endif
endmodule

// File: tb/tb_fft_reorder_buf.sv
// Scoreboard bench for fft_reorder_buf (N=32, WIDTH=16): order, streaming, backpressure, flush, reset.
module tb_fft_reorder_buf;
    localparam int N = 32;
    localparam int W = 16;

    logic clk = 1'b0;
    logic rst_n;
    logic flush;
    fft_reorder_if #(.WIDTH(W)) bus ();

    fft_reorder_buf #(.LOG2N(5), .WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .flush (flush),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    logic [31:0] cur[$];
    logic [31:0] exp_q[$];
    logic [31:0] obs_q[$];
    bit          obs_last[$];
    int          obs_cyc[$];
    int          cyc = 0;
    int          acc_cnt = 0;
    int          checks = 0;
    int          failures = 0;

    function automatic int brev(input int k);
        int r = 0;
        for (int i = 0; i < 5; i++) if (k[i]) r |= (1 << (4 - i));
        return r;
    endfunction

    // Records handshakes seen just before the edge; completed input frames become expected output.
    task automatic tick();
        logic inf, outf;
        @(negedge clk);
        inf  = bus.in_valid & bus.in_ready & ~flush;
        outf = bus.out_valid & bus.out_ready;
        if (outf) begin
            obs_q.push_back({bus.out_r, bus.out_i});
            obs_cyc.push_back(cyc);
`ifdef FFT_REORDER_LAST_EN
            obs_last.push_back(bus.out_last);
`else
            obs_last.push_back(1'b0);
`endif
        end
        if (flush) cur.delete();
        if (inf) begin
            acc_cnt++;
            cur.push_back({bus.in_r, bus.in_i});
            if (cur.size() == N) begin
                for (int j = 0; j < N; j++) exp_q.push_back(cur[brev(j)]);
                cur.delete();
            end
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic clear_model();
        cur.delete(); exp_q.delete(); obs_q.delete(); obs_last.delete(); obs_cyc.delete();
    endtask

    task automatic test_reset();
        rst_n = 1'b0; flush = 1'b0;
        bus.in_valid = 1'b0; bus.in_r = '0; bus.in_i = '0; bus.out_ready = 1'b0;
        #12;
        checks++; if (bus.in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready got=%b exp=1", bus.in_ready); end
        checks++; if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%b exp=0", bus.out_valid); end
        checks++; if (bus.out_r !== '0) begin failures++; $display("FAIL reset_out_r got=%h exp=0", bus.out_r); end
        checks++; if (bus.out_i !== '0) begin failures++; $display("FAIL reset_out_i got=%h exp=0", bus.out_i); end
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_order();
        logic [31:0] o;
        clear_model();
        bus.out_ready = 1'b1;
        for (int k = 0; k < N; k++) begin
            bus.in_valid = 1'b1; bus.in_r = W'(k); bus.in_i = W'(-k);
            tick();
        end
        bus.in_valid = 1'b0;
        for (int t = 0; t < 100 && obs_q.size() < N; t++) tick();
        checks++; if (obs_q.size() != N) begin failures++; $display("FAIL order_count got=%0d exp=%0d", obs_q.size(), N); end
        if (obs_q.size() == N) begin
            checks++; if (obs_q[1][31:16] !== 16'd16) begin failures++; $display("FAIL order_bin1 got=%0d exp=16", obs_q[1][31:16]); end
            checks++; if (obs_q[2][31:16] !== 16'd8) begin failures++; $display("FAIL order_bin2 got=%0d exp=8", obs_q[2][31:16]); end
            checks++; if (obs_q[3][31:16] !== 16'd24) begin failures++; $display("FAIL order_bin3 got=%0d exp=24", obs_q[3][31:16]); end
            checks++; if (obs_q[31][31:16] !== 16'd31) begin failures++; $display("FAIL order_bin31 got=%0d exp=31", obs_q[31][31:16]); end
            for (int j = 0; j < N; j++) begin
                o = obs_q.pop_front();
                checks++;
                if (o[31:16] !== 16'(brev(j)) || o[15:0] !== 16'(-brev(j))) begin
                    failures++; $display("FAIL order[%0d] got=%h exp_r=%0d", j, o, brev(j));
                end
                void'(exp_q.pop_front());
            end
        end
    endtask

    task automatic test_streaming();
        int c31 = -1;
        bit ready_drop = 1'b0;
        logic [31:0] got, want;
        clear_model();
        bus.out_ready = 1'b1;
        for (int k = 0; k < 3*N; k++) begin
            bus.in_valid = 1'b1; bus.in_r = W'($urandom); bus.in_i = W'($urandom);
            if (bus.in_ready !== 1'b1) ready_drop = 1'b1;
            if (k == N-1) c31 = cyc;
            tick();
        end
        bus.in_valid = 1'b0;
        for (int t = 0; t < 200 && obs_q.size() < 3*N; t++) tick();
        checks++; if (ready_drop) begin failures++; $display("FAIL stream_in_ready got=0 exp=1"); end
        checks++; if (obs_q.size() != 3*N) begin failures++; $display("FAIL stream_count got=%0d exp=%0d", obs_q.size(), 3*N); end
        if (obs_q.size() == 3*N) begin
            checks++; if (obs_cyc[0] != c31 + 2) begin failures++; $display("FAIL stream_latency got=%0d exp=%0d", obs_cyc[0], c31 + 2); end
            checks++; if (obs_cyc[3*N-1] != obs_cyc[0] + 3*N - 1) begin failures++; $display("FAIL stream_gapless got=%0d exp=%0d", obs_cyc[3*N-1] - obs_cyc[0], 3*N - 1); end
            for (int j = 0; j < 3*N; j++) begin
                got = obs_q.pop_front(); want = exp_q.pop_front();
                checks++; if (got !== want) begin failures++; $display("FAIL stream[%0d] got=%h exp=%h", j, got, want); end
`ifdef FFT_REORDER_LAST_EN
                checks++; if (obs_last[j] !== ((j % N) == N-1)) begin failures++; $display("FAIL stream_last[%0d] got=%b exp=%b", j, obs_last[j], (j % N) == N-1); end
`endif
            end
        end
    endtask

    task automatic test_backpressure();
        logic [31:0] snap, got, want;
        clear_model();
        acc_cnt = 0;
        bus.out_ready = 1'b0;
        for (int k = 0; k < 80; k++) begin
            bus.in_valid = 1'b1; bus.in_r = W'($urandom); bus.in_i = W'($urandom);
            if (k == 70) snap = {bus.out_r, bus.out_i};
            tick();
        end
        bus.in_valid = 1'b0;
        checks++; if (acc_cnt != 2*N) begin failures++; $display("FAIL bp_accepted got=%0d exp=%0d", acc_cnt, 2*N); end
        checks++; if (bus.in_ready !== 1'b0) begin failures++; $display("FAIL bp_in_ready got=%b exp=0", bus.in_ready); end
        checks++; if (bus.out_valid !== 1'b1) begin failures++; $display("FAIL bp_out_valid got=%b exp=1", bus.out_valid); end
        checks++; if ({bus.out_r, bus.out_i} !== snap) begin failures++; $display("FAIL bp_stable got=%h exp=%h", {bus.out_r, bus.out_i}, snap); end
        bus.out_ready = 1'b1;
        for (int t = 0; t < 300 && obs_q.size() < 2*N; t++) begin
`ifdef FFT_REORDER_LAST_EN
            if (obs_q.size() == N-1 && bus.out_ready) begin
                bus.out_ready = 1'b0;
                for (int s = 0; s < 3; s++) tick();
                checks++; if (bus.out_last !== 1'b1 || bus.out_valid !== 1'b1) begin failures++; $display("FAIL bp_last_hold got=%b/%b exp=1/1", bus.out_last, bus.out_valid); end
                bus.out_ready = 1'b1;
            end
`endif
            tick();
        end
        checks++; if (obs_q.size() != 2*N) begin failures++; $display("FAIL bp_count got=%0d exp=%0d", obs_q.size(), 2*N); end
        while (obs_q.size() > 0 && exp_q.size() > 0) begin
            got = obs_q.pop_front(); want = exp_q.pop_front();
            checks++; if (got !== want) begin failures++; $display("FAIL bp_data got=%h exp=%h", got, want); end
        end
    endtask

    task automatic test_flush();
        logic [31:0] got, want;
        clear_model();
        bus.out_ready = 1'b1;
        for (int k = 0; k < 10; k++) begin
            bus.in_valid = 1'b1; bus.in_r = W'(16'hA000 + k); bus.in_i = W'(16'h5000 + k);
            tick();
        end
        flush = 1'b1; bus.in_r = 16'hDEAD; bus.in_i = 16'hBEEF;
        tick();
        flush = 1'b0; bus.in_valid = 1'b0;
        checks++; if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL flush_out_valid got=%b exp=0", bus.out_valid); end
        checks++; if (bus.in_ready !== 1'b1) begin failures++; $display("FAIL flush_in_ready got=%b exp=1", bus.in_ready); end
        for (int k = 0; k < N; k++) begin
            bus.in_valid = 1'b1; bus.in_r = W'($urandom); bus.in_i = W'($urandom);
            tick();
        end
        bus.in_valid = 1'b0;
        for (int t = 0; t < 60; t++) tick();
        checks++; if (obs_q.size() != N) begin failures++; $display("FAIL flush_count got=%0d exp=%0d", obs_q.size(), N); end
        while (obs_q.size() > 0 && exp_q.size() > 0) begin
            got = obs_q.pop_front(); want = exp_q.pop_front();
            checks++; if (got !== want) begin failures++; $display("FAIL flush_data got=%h exp=%h", got, want); end
        end
    endtask

    task automatic test_reset_mid();
        clear_model();
        bus.out_ready = 1'b1;
        for (int k = 0; k < 40; k++) begin
            bus.in_valid = 1'b1; bus.in_r = W'(k + 1); bus.in_i = W'(k + 7);
            tick();
        end
        #1 rst_n = 1'b0;
        #1;
        checks++; if (bus.in_ready !== 1'b1) begin failures++; $display("FAIL midrst_in_ready got=%b exp=1", bus.in_ready); end
        checks++; if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL midrst_out_valid got=%b exp=0", bus.out_valid); end
        checks++; if (bus.out_r !== '0 || bus.out_i !== '0) begin failures++; $display("FAIL midrst_data got=%h exp=0", {bus.out_r, bus.out_i}); end
        bus.in_valid = 1'b0;
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    initial begin
        test_reset();
        test_order();
        test_streaming();
        test_backpressure();
        test_flush();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
